// File: rtl/fifo_sched.sv
// Write arbiter and burst read scheduler sitting between two pixel producers,
// an external 8-bit FIFO and a burst consumer.
module fifo_sched #(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0,
  input  logic                         req1,
  input  logic [7:0]                   data0,
  input  logic [7:0]                   data1,
  output logic                         gnt0,
  output logic                         gnt1,
  output logic                         wr,
  output logic [7:0]                   data_in,
  output logic                         rd,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  input  logic [7:0]                   data_out,
  input  logic                         burst_req,
  output logic                         busy,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  output logic                         burst_done,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  // state  | meaning
  // IDLE   | no burst in progress, accepting burst_req
  // WAIT   | burst accepted, waiting for BURST_LEN words
  // READ   | issuing BURST_LEN consecutive rd strobes
  // DRAIN  | last word presented on out_data, burst_done high
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int              OW      = $clog2(DEPTH + 1);
  localparam logic [OW-1:0]   DEPTH_W = OW'(DEPTH);
  localparam logic [OW-1:0]   BL_W    = OW'(BURST_LEN);

  state_t          r_state;
  logic [OW-1:0]   r_occ;
  logic [OW-1:0]   r_cnt;
  logic            r_rd;
  logic            r_busy;
  logic            r_ov;
  logic            r_done;
  logic            r_last1;

  logic            w_block;
  logic            w_en;
  logic            w_g0;
  logic            w_g1;
  logic            w_wr;
  logic            w_have_burst;
  logic            w_unused;

  // Occupancy is tracked locally; fifo_empty is implied by it and not needed.
  assign w_unused = fifo_empty;

  // rst_n is active high: writes are suppressed while it is asserted.
  assign w_block = (r_occ == DEPTH_W) || fifo_full;
  assign w_en    = ~rst_n & ~w_block;

  // r_last1 = 1 means req1 won last, so req0 wins a tie next.
  assign w_g0 = w_en & req0 & (~req1 | r_last1);
  assign w_g1 = w_en & req1 & (~req0 | ~r_last1);
  assign w_wr = w_g0 | w_g1;

  assign gnt0    = w_g0;
  assign gnt1    = w_g1;
  assign wr      = w_wr;
  assign data_in = w_g0 ? data0 : (w_g1 ? data1 : 8'h00);

  assign w_have_burst = (r_occ >= BL_W);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_last1 <= 1'b1;
    end else if (w_g0) begin
      r_last1 <= 1'b0;
    end else if (w_g1) begin
      r_last1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_wr, r_rd})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_ov    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ov   <= r_rd;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (burst_req) begin
            r_busy <= 1'b1;
            if (w_have_burst) begin
              r_state <= ST_READ;
              r_rd    <= 1'b1;
              r_cnt   <= BL_W - 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_have_burst) begin
            r_state <= ST_READ;
            r_rd    <= 1'b1;
            r_cnt   <= BL_W - 1'b1;
          end
        end
        ST_READ: begin
          // r_cnt holds the number of strobes still to follow this one.
          if (r_cnt == '0) begin
            r_rd    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd         = r_rd;
  assign busy       = r_busy;
  assign out_valid  = r_ov;
  assign out_data   = r_ov ? data_out : 8'h00;
  assign burst_done = r_done;
  assign occupancy  = r_occ;

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: external FIFO model, queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fifo_sched;
  localparam int DEPTH = 16;
  localparam int BL    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req0, req1, fifo_full, fifo_empty, burst_req;
  logic [7:0] data0, data1, data_out;
  logic       gnt0, gnt1, wr, rd, busy, out_valid, burst_done;
  logic [7:0] data_in, out_data;
  logic [4:0] occupancy;

  fifo_sched #(.DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .wr(wr), .data_in(data_in), .rd(rd), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .data_out(data_out), .burst_req(burst_req),
    .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .burst_done(burst_done), .occupancy(occupancy)
  );

  int checks = 0;
  int errors = 0;

  // environment FIFO, driven by the DUT's actual strobes
  logic [7:0] env_q[$];
  bit         force_full;

  // reference model
  int         m_occ, m_rd_left;
  bit         m_last1, m_busy, m_waiting, m_rd, m_ov, m_done;
  logic [7:0] m_od;
  logic [7:0] sb_q[$];

  // captured DUT values and running totals
  bit         c_g0, c_g1, c_wr, c_rd, c_busy, c_ov, c_done;
  logic [7:0] c_din;
  int         c_occ;
  int         g_rd, g_ov, g_done, g_wr, g_ov_at_done;
  bit         chk_const;
  int         occ_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_last1 = 1'b1; m_busy = 0; m_waiting = 0; m_rd = 0;
    m_rd_left = 0; m_ov = 0; m_done = 0; m_od = 8'h00;
    sb_q.delete();
  endtask

  task automatic set_flags();
    fifo_empty = (env_q.size() == 0);
    fifo_full  = (env_q.size() >= DEPTH) || force_full;
  endtask

  task automatic tick();
    bit blk, eg0, eg1, ewr, nov, ndone;
    logic [7:0] edin, nod;
    int occ_now;
    set_flags();
    @(negedge clk);
    blk  = (m_occ == DEPTH) || fifo_full;
    eg0  = !rst_n && !blk && req0 && (!req1 || m_last1);
    eg1  = !rst_n && !blk && req1 && (!req0 || !m_last1);
    ewr  = eg0 | eg1;
    edin = eg0 ? data0 : (eg1 ? data1 : 8'h00);
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("wr", wr, ewr);
    chk("data_in", data_in, edin);
    chk("rd", rd, m_rd);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_ov ? m_od : 8'h00);
    chk("burst_done", burst_done, m_done);
    chk("occupancy", occupancy, m_occ);
    chk("rd_when_empty", rd & fifo_empty, 0);
    c_g0 = gnt0; c_g1 = gnt1; c_wr = wr; c_din = data_in; c_rd = rd;
    c_busy = busy; c_ov = out_valid; c_done = burst_done; c_occ = occupancy;
    if (c_rd) g_rd++;
    if (c_wr) g_wr++;
    if (c_ov) g_ov++;
    if (c_done) begin g_done++; g_ov_at_done = g_ov; end
    if (chk_const && c_rd) begin
      if (occ_first < 0) occ_first = c_occ;
      else chk("rw_occ_const", c_occ, occ_first);
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      env_q.delete();
      model_reset();
    end else begin
      if (c_rd && env_q.size() > 0) data_out = env_q.pop_front();
      if (c_wr) env_q.push_back(c_din);
      occ_now = m_occ;
      m_occ = m_occ + (ewr ? 1 : 0) - (m_rd ? 1 : 0);
      if (eg0) m_last1 = 1'b0;
      else if (eg1) m_last1 = 1'b1;
      if (ewr) sb_q.push_back(edin);
      nov = m_rd;
      nod = 8'h00;
      if (m_rd) nod = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      ndone = m_rd && (m_rd_left == 1);
      if (m_done) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (burst_req) begin
          m_busy = 1;
          if (occ_now >= BL) begin m_rd = 1; m_rd_left = BL; end
          else m_waiting = 1;
        end
      end else if (m_waiting) begin
        if (occ_now >= BL) begin m_waiting = 0; m_rd = 1; m_rd_left = BL; end
      end else if (m_rd) begin
        m_rd_left--;
        if (m_rd_left == 0) m_rd = 0;
      end
      m_ov = nov; m_od = nod; m_done = ndone;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1; req0 = 0; req1 = 0; burst_req = 0; force_full = 0;
    tick(); tick();
    rst_n = 0;
  endtask

  task automatic write_words(input int n);
    req0 = 1;
    for (int i = 0; i < n; i++) begin data0 = 8'(8'h40 + i); tick(); end
    req0 = 0;
  endtask

  task automatic run_burst();
    int d0;
    bit ok;
    d0 = g_done; ok = 0;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (g_done != d0 && !c_busy) begin ok = 1; break; end
    end
    chk("burst_completes", ok, 1);
  endtask

  int s_rd, s_ov, s_done, s_wr;
  bit full_ok;

  initial begin
    rst_n = 1; req0 = 0; req1 = 0; data0 = 0; data1 = 0; burst_req = 0;
    force_full = 0; data_out = 0; chk_const = 0; occ_first = -1;
    model_reset();
    set_flags();
    @(posedge clk); #1;
    apply_reset();
    tick();
    chk("reset_occ", c_occ, 0);
    chk("reset_busy", c_busy, 0);

    // alternating grants from reset
    apply_reset();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      data0 = 8'(8'h10 + i); data1 = 8'(8'h20 + i);
      tick();
      chk("alt_gnt1", c_g1, i % 2);
      chk("alt_din", c_din, (i % 2) ? 8'(8'h20 + i) : 8'(8'h10 + i));
    end
    req0 = 0; req1 = 0;
    tick();
    chk("alt_occ", c_occ, 6);

    // full boundary
    apply_reset();
    req0 = 1; data0 = 8'h5a; full_ok = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (c_occ == DEPTH) begin full_ok = 1; break; end
    end
    chk("reached_full", full_ok, 1);
    tick();
    chk("full_gnt0", c_g0, 0);
    chk("full_occ", c_occ, 16);
    s_wr = g_wr; s_rd = g_rd;
    burst_req = 1; tick(); burst_req = 0;
    run_burst();
    chk("full_wr_count", g_wr - s_wr, 4);
    chk("full_wr_per_rd", g_wr - s_wr, g_rd - s_rd);
    chk("full_occ_after", c_occ, 16);
    req0 = 0;

    // burst that has to wait for data
    apply_reset();
    write_words(2);
    s_rd = g_rd; s_ov = g_ov; s_done = g_done;
    burst_req = 1; tick(); burst_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_busy", c_busy, 1);
      chk("wait_no_rd", c_rd, 0);
    end
    write_words(2);
    run_burst();
    chk("wait_rd_count", g_rd - s_rd, 4);
    chk("wait_ov_count", g_ov - s_ov, 4);
    chk("wait_done_count", g_done - s_done, 1);
    chk("wait_done_on_4th", g_ov_at_done - s_ov, 4);
    chk("wait_busy_after", c_busy, 0);

    // concurrent read and write
    apply_reset();
    write_words(6);
    req1 = 1; data1 = 8'h77; chk_const = 1; occ_first = -1;
    burst_req = 1; tick(); burst_req = 0;
    run_burst();
    chk_const = 0; req1 = 0;

    // reset in the middle of a burst
    apply_reset();
    write_words(6);
    s_done = g_done;
    burst_req = 1; tick(); burst_req = 0;
    for (int t = 0; t < 10 && !c_rd; t++) tick();
    chk("mid_first_rd", c_rd, 1);
    rst_n = 1;
    tick();
    chk("mid_second_rd", c_rd, 1);
    rst_n = 0;
    tick();
    chk("mid_rd", c_rd, 0);
    chk("mid_ov", c_ov, 0);
    chk("mid_busy", c_busy, 0);
    chk("mid_occ", c_occ, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_no_done", g_done - s_done, 0);

    // request while busy is ignored
    apply_reset();
    write_words(8);
    s_rd = g_rd; s_done = g_done;
    burst_req = 1; tick(); burst_req = 0;
    tick();
    burst_req = 1; tick(); burst_req = 0;
    run_burst();
    for (int i = 0; i < 10; i++) tick();
    chk("ignored_done_count", g_done - s_done, 1);
    chk("ignored_rd_count", g_rd - s_rd, 4);

    // randomized traffic
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) == 0);
      req0       = 1'($urandom_range(0, 1));
      req1       = 1'($urandom_range(0, 1));
      data0      = 8'($urandom);
      data1      = 8'($urandom);
      burst_req  = ($urandom_range(0, 9) == 0);
      force_full = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
